// File: rtl/wu_trial_sequencer.sv
// Wake-up receiver trial sequencer: fires signal-generator triggers, classifies wake-ups as hit/miss/false.
// Define WU_SEQ_LATENCY_STATS_EN to add lat_min/lat_max/lat_sum outputs.
module wu_trial_sequencer #(
  parameter int TRIG_W = 16,
  parameter int CNT_W  = 20,
  parameter int LAT_W  = 24
) (
  input  logic             clki,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_trials,
  input  logic [31:0]      trig_period,
  input  logic [LAT_W-1:0] resp_window,
  input  logic             sc_busy,
  input  logic             wake_up,
  output logic             trig_to_siggen,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] trial_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] false_cnt,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_data,
`ifdef WU_SEQ_LATENCY_STATS_EN
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max,
  output logic [31:0]      lat_sum,
`endif
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ARM, S_TRIG, S_WINDOW, S_HOLDOFF, S_DONE
  } state_t;

  localparam logic [31:0]      TRIG_LEN = 32'(TRIG_W);
  localparam logic [31:0]      MIN_PER  = 32'(TRIG_W + 1);
  localparam logic [31:0]      ONE32    = 32'd1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_MAX  = {LAT_W{1'b1}};

  state_t           state, adv_state;
  logic             start_q, wake_meta, wake_sync, wake_prev, hit_seen;
  logic [CNT_W-1:0] n_lat, trial_nx;
  logic [31:0]      ep_r, ew_r, phase, phase_nx, eff_per_c, eff_win_c;
  logic             start_rise, wake_edge, active, in_win, win_last, last_cyc;
  logic             take_hit, take_false, take_miss;
  logic [LAT_W-1:0] lat_now;
`ifdef WU_SEQ_LATENCY_STATS_EN
  logic [32:0]      sum_nx;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign state_dbg = state;

  always_comb begin
    start_rise = start & ~start_q;
    wake_edge  = wake_sync & ~wake_prev;
    eff_per_c  = (trig_period < MIN_PER) ? MIN_PER : trig_period;
    eff_win_c  = (32'(resp_window) < eff_per_c - ONE32) ? 32'(resp_window) : eff_per_c - ONE32;
    active     = (state == S_TRIG) || (state == S_WINDOW) || (state == S_HOLDOFF);
    in_win     = phase < ew_r;
    // An empty window still closes (as a miss) on the first trigger cycle.
    win_last   = (ew_r == 32'd0) ? (phase == 32'd0) : (phase == ew_r - ONE32);
    last_cyc   = phase == ep_r - ONE32;
    take_hit   = active & wake_edge & in_win & ~hit_seen;
    take_false = active & wake_edge & ~take_hit;
    take_miss  = active & win_last & ~hit_seen & ~take_hit;
    phase_nx   = phase + ONE32;
    trial_nx   = sat_inc(trial_cnt);
    lat_now    = (phase > 32'(LAT_MAX)) ? LAT_MAX : phase[LAT_W-1:0];
    if (phase_nx < TRIG_LEN)  adv_state = S_TRIG;
    else if (phase_nx < ew_r) adv_state = S_WINDOW;
    else                      adv_state = S_HOLDOFF;
`ifdef WU_SEQ_LATENCY_STATS_EN
    sum_nx = {1'b0, lat_sum} + 33'(lat_now);
`endif
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      state <= S_IDLE;
      start_q <= 1'b0; wake_meta <= 1'b0; wake_sync <= 1'b0; wake_prev <= 1'b0;
      hit_seen <= 1'b0; n_lat <= '0; ep_r <= '0; ew_r <= '0; phase <= '0;
      trig_to_siggen <= 1'b0; busy <= 1'b0; done <= 1'b0;
      trial_cnt <= '0; hit_cnt <= '0; miss_cnt <= '0; false_cnt <= '0;
      lat_valid <= 1'b0; lat_data <= '0;
`ifdef WU_SEQ_LATENCY_STATS_EN
      lat_min <= LAT_MAX; lat_max <= '0; lat_sum <= '0;
`endif
    end else begin
      start_q   <= start;
      wake_meta <= wake_up;
      wake_sync <= wake_meta;
      wake_prev <= wake_sync;
      lat_valid <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE; trig_to_siggen <= 1'b0; busy <= 1'b0; done <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: if (start_rise) begin
            n_lat <= num_trials; ep_r <= eff_per_c; ew_r <= eff_win_c;
            trial_cnt <= '0; hit_cnt <= '0; miss_cnt <= '0; false_cnt <= '0;
            done <= 1'b0; state <= S_LAUNCH;
`ifdef WU_SEQ_LATENCY_STATS_EN
            lat_min <= LAT_MAX; lat_max <= '0; lat_sum <= '0;
`endif
          end
          S_LAUNCH: begin
            if (n_lat == '0) begin
              state <= S_DONE; done <= 1'b1;
            end else begin
              state <= S_ARM; busy <= 1'b1;
            end
          end
          S_ARM: if (!sc_busy) begin
            state <= S_TRIG; trig_to_siggen <= 1'b1; phase <= '0; hit_seen <= 1'b0;
          end
          S_TRIG, S_WINDOW, S_HOLDOFF: begin
            phase <= phase_nx;
            if (take_hit) begin
              hit_cnt <= sat_inc(hit_cnt); hit_seen <= 1'b1;
              lat_valid <= 1'b1; lat_data <= lat_now;
`ifdef WU_SEQ_LATENCY_STATS_EN
              if (lat_now < lat_min) lat_min <= lat_now;
              if (lat_now > lat_max) lat_max <= lat_now;
              lat_sum <= sum_nx[32] ? 32'hFFFF_FFFF : sum_nx[31:0];
`endif
            end
            if (take_false) false_cnt <= sat_inc(false_cnt);
            if (take_miss)  miss_cnt  <= sat_inc(miss_cnt);
            if (last_cyc) begin
              trial_cnt <= trial_nx;
              // Arming is folded into the last holdoff cycle so an idle scan chain gives exact periods.
              if (trial_nx == n_lat) begin
                state <= S_DONE; done <= 1'b1; busy <= 1'b0; trig_to_siggen <= 1'b0;
              end else if (!sc_busy) begin
                state <= S_TRIG; trig_to_siggen <= 1'b1; phase <= '0; hit_seen <= 1'b0;
              end else begin
                state <= S_ARM; trig_to_siggen <= 1'b0;
              end
            end else begin
              state <= adv_state;
              trig_to_siggen <= (phase_nx < TRIG_LEN);
            end
          end
          default: begin
            state <= S_IDLE; trig_to_siggen <= 1'b0; busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
